vme_func_ader_decoder: RTL and testbench

- Synthesisable multi-function VME64x address decoder for the SVEC VME slave path.
- Holds N CR/CSR-programmable ADER registers plus the module-enable bit.
- Matches each incoming VME address/AM against all enabled functions in a 2-stage pipeline and returns hit plus function index.
- Generalises the single-function (ADER0, A32) setup to N functions with per-function ADEM masks and XAM rejection.

---
 rtl/vme_func_ader_decoder_pkg.sv | 29 ++
 rtl/vme_func_ader_decoder_if.sv | 29 ++
 rtl/vme_func_ader_decoder_match.sv | 24 ++
 rtl/vme_func_ader_decoder.sv | 141 ++++++++++++++
 tb/tb_vme_func_ader_decoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vme_func_ader_decoder_pkg.sv
// Shared constants, ADER record type and CR/CSR address helper for the
// multi-function VME64x ADER decoder.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package vme_func_dec_pkg;

  localparam logic [18:0] c_BIT_SET_ADDR      = 19'h7FFFB;
  localparam logic [18:0] c_BIT_CLR_ADDR      = 19'h7FFF7;
  localparam int          c_ENABLE_BIT        = 4;
  localparam int          c_MAX_FUNC          = 8;
  localparam logic [18:0] c_DEFAULT_ADER_BASE = 19'h7FF63;

  // One function's ADER as stored; the reserved bit 1 is not kept.
  typedef struct packed {
    logic [23:0] compare;  // ADER[31:8]
    logic [5:0]  am;       // ADER[7:2]
    logic        xam;      // ADER[0]
  } t_ader;

  // CR/CSR byte address of ADERn byte k (byte 0 is the MSB). ADER
  // registers sit on a 16-byte stride, bytes on a 4-byte stride.
  function automatic logic [18:0] f_ader_byte_addr(
    input int          n,
    input int          k,
    input logic [18:0] base = c_DEFAULT_ADER_BASE
  );
    return base + 19'(16 * n + 4 * k);
  endfunction

endpackage

// File: rtl/vme_func_ader_decoder_if.sv
// CR/CSR byte-access and decode request/result bundle of the ADER decoder.
// Latency: n/a (wires only). Backpressure: none; requests are never stalled.
// master = CR/CSR + VME address source, slave = the decoder.
interface vme_func_ader_decoder_if;
  logic        csr_we_i;
  logic        csr_re_i;
  logic [18:0] csr_addr_i;
  logic [7:0]  csr_data_i;
  logic [7:0]  csr_rdata_o;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic [5:0]  req_am_i;
  logic        dec_valid_o;
  logic        dec_hit_o;
  logic [2:0]  dec_func_o;
  logic        module_en_o;

  modport master (
    output csr_we_i, csr_re_i, csr_addr_i, csr_data_i,
    output req_valid_i, req_addr_i, req_am_i,
    input  csr_rdata_o, dec_valid_o, dec_hit_o, dec_func_o, module_en_o
  );

  modport slave (
    input  csr_we_i, csr_re_i, csr_addr_i, csr_data_i,
    input  req_valid_i, req_addr_i, req_am_i,
    output csr_rdata_o, dec_valid_o, dec_hit_o, dec_func_o, module_en_o
  );
endinterface

// File: rtl/vme_func_ader_decoder_match.sv
// Single-function address/AM compare against one ADER/ADEM pair.
// Latency: combinational. Backpressure: none.
// Ports: module_en, adem (full 32-bit mask), ader, addr (VME A[31:8]), am -> match.
module vme_func_match
  import vme_func_dec_pkg::*;
(
  input  logic        module_en,
  input  logic [31:0] adem,
  input  t_ader       ader,
  input  logic [23:0] addr,
  input  logic [5:0]  am,
  output logic        match
);

  logic addr_eq;

  // Only bits the ADEM marks as decoded take part in the compare.
  assign addr_eq = ((addr ^ ader.compare) & adem[31:8]) == 24'h000000;

  // XAM functions are never matched: extended AM decoding is not built.
  assign match = module_en && (adem != 32'h00000000) && !ader.xam &&
                 (ader.am == am) && addr_eq;

endmodule

// File: rtl/vme_func_ader_decoder.sv
// Multi-function VME64x ADER decoder: CR/CSR-programmable ADERs + enable,
// address/AM match for all functions, lowest-index hit reported.
// Latency: 2 cycles request->result, fully pipelined; CSR read data 1 cycle.
// Backpressure: none; one request per cycle is always accepted.
// Ports: clk_i, rst_i (sync, active high), bus (CSR byte access, decode
// request/result, module enable).
module vme_func_ader_decoder
  import vme_func_dec_pkg::*;
#(
  parameter int                          g_NUM_FUNC      = 8,
  parameter logic [c_MAX_FUNC*32-1:0]    g_ADEM          = {c_MAX_FUNC{32'hFF000000}},
  parameter logic [18:0]                 g_CSR_ADER_BASE = 19'h7FF63
)
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  vme_func_ader_decoder_if.slave   bus
);

  t_ader [g_NUM_FUNC-1:0] ader_q;
  logic                   module_en_q;
  logic [7:0]             rd_byte;
  logic [7:0]             rdata_q;

  logic [g_NUM_FUNC-1:0]  match_vec;
  logic                   s1_vld_q;
  logic [g_NUM_FUNC-1:0]  s1_match_q;
  logic [2:0]             enc_func;
  logic                   dec_vld_q;
  logic                   dec_hit_q;
  logic [2:0]             dec_func_q;

  // A[7:0] lies below every ADEM's significant range.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr_i[7:0];

  // ---------------------------------------------------------------- CSR write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ader_q      <= '0;
      module_en_q <= 1'b0;
    end else if (bus.csr_we_i) begin
      for (int n = 0; n < g_NUM_FUNC; n++) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.csr_addr_i == f_ader_byte_addr(n, k, g_CSR_ADER_BASE)) begin
            case (k)
              0: ader_q[n].compare[23:16] <= bus.csr_data_i;
              1: ader_q[n].compare[15:8]  <= bus.csr_data_i;
              2: ader_q[n].compare[7:0]   <= bus.csr_data_i;
              3: begin
                ader_q[n].am  <= bus.csr_data_i[7:2];
                ader_q[n].xam <= bus.csr_data_i[0];
              end
              default: ;
            endcase
          end
        end
      end
      if (bus.csr_addr_i == c_BIT_SET_ADDR && bus.csr_data_i[c_ENABLE_BIT])
        module_en_q <= 1'b1;
      if (bus.csr_addr_i == c_BIT_CLR_ADDR && bus.csr_data_i[c_ENABLE_BIT])
        module_en_q <= 1'b0;
    end
  end

  // ----------------------------------------------------------------- CSR read
  // Read mux looks at the registered state, so a read in the same cycle as a
  // write to the same byte returns the pre-write value.
  always_comb begin
    rd_byte = 8'h00;
    for (int n = 0; n < g_NUM_FUNC; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.csr_addr_i == f_ader_byte_addr(n, k, g_CSR_ADER_BASE)) begin
          case (k)
            0:       rd_byte = ader_q[n].compare[23:16];
            1:       rd_byte = ader_q[n].compare[15:8];
            2:       rd_byte = ader_q[n].compare[7:0];
            3:       rd_byte = {ader_q[n].am, 1'b0, ader_q[n].xam};
            default: rd_byte = 8'h00;
          endcase
        end
      end
    end
    if (bus.csr_addr_i == c_BIT_SET_ADDR || bus.csr_addr_i == c_BIT_CLR_ADDR)
      rd_byte = {3'b000, module_en_q, 4'b0000};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      rdata_q <= 8'h00;
    else if (bus.csr_re_i)
      rdata_q <= rd_byte;
  end

  // ------------------------------------------------------- per-function match
  for (genvar gi = 0; gi < g_NUM_FUNC; gi++) begin : g_func
    vme_func_match u_match (
      .module_en (module_en_q),
      .adem      (g_ADEM[32*gi +: 32]),
      .ader      (ader_q[gi]),
      .addr      (bus.req_addr_i[31:8]),
      .am        (bus.req_am_i),
      .match     (match_vec[gi])
    );
  end

  // Fixed priority: the lowest matching index wins.
  always_comb begin
    enc_func = 3'd0;
    for (int n = g_NUM_FUNC - 1; n >= 0; n--) begin
      if (s1_match_q[n])
        enc_func = 3'(n);
    end
  end

  // ------------------------------------------------------------ pipeline
  // The stage-1 match vector is zeroed for idle slots, so stage 2 needs no
  // extra qualification to keep hit/func at 0 outside valid results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s1_match_q <= '0;
      dec_vld_q  <= 1'b0;
      dec_hit_q  <= 1'b0;
      dec_func_q <= 3'd0;
    end else begin
      s1_vld_q   <= bus.req_valid_i;
      s1_match_q <= bus.req_valid_i ? match_vec : '0;
      dec_vld_q  <= s1_vld_q;
      dec_hit_q  <= |s1_match_q;
      dec_func_q <= enc_func;
    end
  end

  assign bus.csr_rdata_o = rdata_q;
  assign bus.dec_valid_o = dec_vld_q;
  assign bus.dec_hit_o   = dec_hit_q;
  assign bus.dec_func_o  = dec_func_q;
  assign bus.module_en_o = module_en_q;

endmodule

// File: tb/tb_vme_func_ader_decoder.sv
// Self-checking bench for vme_func_ader_decoder: directed sequences, a vector
// table and a randomized phase scored against a register-level model.
module tb_vme_func_ader_decoder;

  localparam int NF = 8;
  // Function 7: A[31:8], 6..3: A[31:24], 2: A[31:16], 1: disabled, 0: A[31:24].
  localparam logic [255:0] TB_ADEM = {32'hFFFFFF00, {4{32'hFF000000}},
                                      32'hFFFF0000, 32'h00000000, 32'hFF000000};

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  vme_func_ader_decoder_if bus ();
  vme_func_ader_decoder_if bus2 ();

  vme_func_ader_decoder #(
    .g_NUM_FUNC      (NF),
    .g_ADEM          (TB_ADEM),
    .g_CSR_ADER_BASE (19'h7FF63)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  vme_func_ader_decoder #(
    .g_NUM_FUNC (2)
  ) dut2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus2.slave)
  );

  // ------------------------------------------------------------------ model
  logic [31:0] m_ader [NF];
  logic        m_en;

  function automatic logic [18:0] ader_addr(input int n, input int k);
    return 19'h7FF63 + 19'(16 * n + 4 * k);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NF; n++) m_ader[n] = 32'h0;
    m_en = 1'b0;
  endtask

  task automatic model_write(input logic [18:0] a, input logic [7:0] d);
    for (int n = 0; n < NF; n++)
      for (int k = 0; k < 4; k++)
        if (a == ader_addr(n, k))
          m_ader[n][31-8*k -: 8] = (k == 3) ? (d & 8'hFD) : d;
    if (a == 19'h7FFFB && d[4]) m_en = 1'b1;
    if (a == 19'h7FFF7 && d[4]) m_en = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [18:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int n = 0; n < NF; n++)
      for (int k = 0; k < 4; k++)
        if (a == ader_addr(n, k)) v = m_ader[n][31-8*k -: 8];
    if (a == 19'h7FFFB || a == 19'h7FFF7) v = m_en ? 8'h10 : 8'h00;
    return v;
  endfunction

  task automatic model_decode(input logic [31:0] a, input logic [5:0] am,
                              output logic hit, output logic [2:0] func);
    logic [31:0] m;
    hit = 1'b0;
    func = 3'd0;
    for (int n = 0; n < NF; n++) begin
      m = TB_ADEM[32*n +: 32];
      if (!hit && m_en && m != 0 && m_ader[n][0] == 1'b0 &&
          m_ader[n][7:2] == am && ((a ^ m_ader[n]) & m & 32'hFFFFFF00) == 0) begin
        hit = 1'b1;
        func = 3'(n);
      end
    end
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_wr(input logic [18:0] a, input logic [7:0] d);
    bus.csr_we_i = 1'b1; bus.csr_addr_i = a; bus.csr_data_i = d;
    model_write(a, d);
    tick();
    bus.csr_we_i = 1'b0;
  endtask

  task automatic csr_rd_check(input string name, input logic [18:0] a, input logic [7:0] exp);
    bus.csr_re_i = 1'b1; bus.csr_addr_i = a;
    tick();
    bus.csr_re_i = 1'b0;
    check(name, 32'(bus.csr_rdata_o), 32'(exp));
  endtask

  task automatic req_check(input string name, input logic [31:0] a, input logic [5:0] am,
                           input logic hit, input logic [2:0] func);
    bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_am_i = am;
    tick();
    bus.req_valid_i = 1'b0;
    check({name, "_t1"}, 32'(bus.dec_valid_o), 0);
    tick();
    check({name, "_vld"}, 32'(bus.dec_valid_o), 1);
    check({name, "_hit"}, 32'(bus.dec_hit_o), 32'(hit));
    check({name, "_func"}, 32'(bus.dec_func_o), 32'(func));
    tick();
    check({name, "_t3"}, 32'(bus.dec_valid_o), 0);
  endtask

  // --------------------------------------------------- random-phase scoreboard
  typedef struct { int due; logic hit; logic [2:0] func; } dexp_t;
  typedef struct { int due; logic [7:0] dat; } rexp_t;
  dexp_t dq [$];
  rexp_t rq [$];
  dexp_t de;
  rexp_t re_e;

  always @(negedge clk_i) begin
    if (chk_en) begin
      if (dq.size() > 0 && dq[0].due == cyc) begin
        de = dq.pop_front();
        check("rnd_vld", 32'(bus.dec_valid_o), 1);
        check("rnd_hit", 32'(bus.dec_hit_o), 32'(de.hit));
        check("rnd_func", 32'(bus.dec_func_o), 32'(de.func));
      end else begin
        check("rnd_idle", 32'(bus.dec_valid_o), 0);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        re_e = rq.pop_front();
        check("rnd_rdata", 32'(bus.csr_rdata_o), 32'(re_e.dat));
      end
      check("rnd_en", 32'(bus.module_en_o), 32'(m_en));
    end
  end

  // ------------------------------------------------------------ vector table
  typedef struct { logic [31:0] addr; logic [5:0] am; logic hit; logic [2:0] func; } vec_t;
  vec_t vecs [7];

  typedef struct { logic [31:0] addr; logic [5:0] am; logic hit; logic [2:0] func; } b2b_t;
  b2b_t b2b [4];

  initial begin
    logic        h;
    logic [2:0]  f;
    logic [18:0] a;
    logic [7:0]  d;
    int          n;
    int          k;
    int          r;

    vecs[0] = '{32'h80001000, 6'h09, 1'b1, 3'd0};
    vecs[1] = '{32'h80001000, 6'h0D, 1'b0, 3'd0};
    vecs[2] = '{32'h12ABCDEC, 6'h0D, 1'b1, 3'd3};
    vecs[3] = '{32'h12ABCDEC, 6'h09, 1'b0, 3'd0};
    vecs[4] = '{32'h81000000, 6'h09, 1'b0, 3'd0};
    vecs[5] = '{32'h80FFFFFF, 6'h09, 1'b1, 3'd0};
    vecs[6] = '{32'h13000000, 6'h0D, 1'b0, 3'd0};
    b2b[0]  = '{32'h80000000, 6'h09, 1'b1, 3'd0};
    b2b[1]  = '{32'h81000000, 6'h09, 1'b0, 3'd0};
    b2b[2]  = '{32'h12000000, 6'h0D, 1'b1, 3'd3};
    b2b[3]  = '{32'h12000000, 6'h09, 1'b0, 3'd0};

    bus.csr_we_i = 0; bus.csr_re_i = 0; bus.csr_addr_i = 0; bus.csr_data_i = 0;
    bus.req_valid_i = 0; bus.req_addr_i = 0; bus.req_am_i = 0;
    bus2.csr_we_i = 0; bus2.csr_re_i = 0; bus2.csr_addr_i = 0; bus2.csr_data_i = 0;
    bus2.req_valid_i = 0; bus2.req_addr_i = 0; bus2.req_am_i = 0;
    model_reset();

    // Reset state.
    repeat (3) tick();
    check("rst_vld", 32'(bus.dec_valid_o), 0);
    check("rst_hit", 32'(bus.dec_hit_o), 0);
    check("rst_func", 32'(bus.dec_func_o), 0);
    check("rst_en", 32'(bus.module_en_o), 0);
    check("rst_rdata", 32'(bus.csr_rdata_o), 0);
    rst_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++)
      csr_rd_check($sformatf("rst_ader0_b%0d", i), ader_addr(0, i), 8'h00);
    csr_rd_check("rst_bitset", 19'h7FFFB, 8'h00);
    req_check("rst_req", 32'h80001000, 6'h09, 1'b0, 3'd0);

    // Single function A32.
    csr_wr(19'h7FF63, 8'h80);
    csr_wr(19'h7FF6F, 8'h24);
    csr_wr(19'h7FFFB, 8'h10);
    check("en_set", 32'(bus.module_en_o), 1);
    req_check("f0_hit", 32'h80001000, 6'h09, 1'b1, 3'd0);
    req_check("f0_am_miss", 32'h80001000, 6'h0D, 1'b0, 3'd0);
    csr_rd_check("ader0_b0", 19'h7FF63, 8'h80);
    csr_rd_check("ader0_b3", 19'h7FF6F, 8'h24);
    csr_wr(19'h7FF6F, 8'h27);
    csr_rd_check("ader0_rsvd", 19'h7FF6F, 8'h25);
    csr_wr(19'h7FF6F, 8'h24);

    // Priority between two functions.
    csr_wr(19'h7FF93, 8'h80);
    csr_wr(19'h7FF9F, 8'h24);
    req_check("prio_f0", 32'h80000000, 6'h09, 1'b1, 3'd0);
    csr_wr(19'h7FF6F, 8'h00);
    req_check("prio_f3", 32'h80000000, 6'h09, 1'b1, 3'd3);
    csr_wr(19'h7FF6F, 8'h24);

    // Read and write of the same byte in one cycle returns the old value.
    bus.csr_we_i = 1; bus.csr_re_i = 1; bus.csr_addr_i = 19'h7FF63; bus.csr_data_i = 8'h55;
    model_write(19'h7FF63, 8'h55);
    tick();
    bus.csr_we_i = 0; bus.csr_re_i = 0;
    check("rw_old", 32'(bus.csr_rdata_o), 32'h80);
    csr_rd_check("rw_new", 19'h7FF63, 8'h55);
    csr_wr(19'h7FF63, 8'h80);

    // BIT_CLR with a request in the same cycle.
    bus.csr_we_i = 1; bus.csr_addr_i = 19'h7FFF7; bus.csr_data_i = 8'h10;
    bus.req_valid_i = 1; bus.req_addr_i = 32'h80000000; bus.req_am_i = 6'h09;
    model_write(19'h7FFF7, 8'h10);
    tick();
    bus.csr_we_i = 0; bus.req_valid_i = 0;
    check("clr_en", 32'(bus.module_en_o), 0);
    tick();
    check("clr_same_vld", 32'(bus.dec_valid_o), 1);
    check("clr_same_hit", 32'(bus.dec_hit_o), 1);
    check("clr_same_func", 32'(bus.dec_func_o), 0);
    tick();
    req_check("clr_after", 32'h80000000, 6'h09, 1'b0, 3'd0);
    csr_rd_check("clr_rd_clr", 19'h7FFF7, 8'h00);
    csr_rd_check("clr_rd_set", 19'h7FFFB, 8'h00);
    csr_wr(19'h7FFFB, 8'h10);
    csr_rd_check("set_rd_clr", 19'h7FFF7, 8'h10);
    csr_wr(19'h7FFF7, 8'hEF);
    check("clr_bit4_zero", 32'(bus.module_en_o), 1);
    csr_rd_check("oom_rd", 19'h00000, 8'h00);
    csr_wr(19'h7FF64, 8'hFF);
    csr_rd_check("oom_wr", 19'h7FF64, 8'h00);

    // Vector table.
    csr_wr(19'h7FF93, 8'h12);
    csr_wr(19'h7FF9F, 8'h34);
    for (int i = 0; i < 7; i++)
      req_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].am, vecs[i].hit, vecs[i].func);

    // Back-to-back stream: result i appears after tick i+1.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.req_valid_i = 1; bus.req_addr_i = b2b[i].addr; bus.req_am_i = b2b[i].am;
      end else begin
        bus.req_valid_i = 0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("b2b%0d_vld", i - 1), 32'(bus.dec_valid_o), 1);
        check($sformatf("b2b%0d_hit", i - 1), 32'(bus.dec_hit_o), 32'(b2b[i-1].hit));
        check($sformatf("b2b%0d_func", i - 1), 32'(bus.dec_func_o), 32'(b2b[i-1].func));
      end else if (i == 5) begin
        check("b2b_end", 32'(bus.dec_valid_o), 0);
      end
    end

    // Reset one cycle after a matching request.
    bus.req_valid_i = 1; bus.req_addr_i = 32'h80000000; bus.req_am_i = 6'h09;
    tick();
    bus.req_valid_i = 0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_reset();
    check("mid_rst_vld", 32'(bus.dec_valid_o), 0);
    check("mid_rst_hit", 32'(bus.dec_hit_o), 0);
    check("mid_rst_func", 32'(bus.dec_func_o), 0);
    check("mid_rst_en", 32'(bus.module_en_o), 0);
    tick();
    check("mid_rst_vld2", 32'(bus.dec_valid_o), 0);

    // XAM functions never match.
    csr_wr(19'h7FF63, 8'h80);
    csr_wr(19'h7FF6F, 8'h25);
    csr_wr(19'h7FFFB, 8'h10);
    csr_rd_check("xam_rd", 19'h7FF6F, 8'h25);
    req_check("xam_miss", 32'h80000000, 6'h09, 1'b0, 3'd0);
    csr_wr(19'h7FF6F, 8'h24);
    req_check("xam_off_hit", 32'h80000000, 6'h09, 1'b1, 3'd0);

    // Two-function instance: ADER2 does not exist.
    bus2.csr_we_i = 1; bus2.csr_addr_i = 19'h7FF83; bus2.csr_data_i = 8'h80;
    tick();
    bus2.csr_we_i = 0; bus2.csr_re_i = 1;
    tick();
    bus2.csr_re_i = 0;
    check("nf2_ader2", 32'(bus2.csr_rdata_o), 0);
    bus2.csr_we_i = 1; bus2.csr_addr_i = 19'h7FF73; bus2.csr_data_i = 8'h80;
    tick();
    bus2.csr_we_i = 0; bus2.csr_re_i = 1;
    tick();
    bus2.csr_re_i = 0;
    check("nf2_ader1", 32'(bus2.csr_rdata_o), 32'h80);

    // Randomized phase against the model.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(0, NF - 1);
      k = $urandom_range(0, 3);
      d = 8'($urandom);
      if (r < 7) begin
        a = ader_addr(n, k);
        if (k == 3)
          d = {($urandom_range(0, 1) == 1) ? 6'h09 : 6'h0D, d[1], ($urandom_range(0, 7) == 0)};
      end else if (r == 7) begin
        a = 19'h7FFFB;
        if ($urandom_range(0, 3) != 0) d = 8'h10;
      end else if (r == 8) begin
        a = 19'h7FFF7;
        if ($urandom_range(0, 3) != 0) d = 8'h10;
      end else begin
        a = 19'($urandom);
      end
      bus.csr_we_i = ($urandom_range(0, 2) == 0);
      bus.csr_re_i = ($urandom_range(0, 3) == 0);
      bus.csr_addr_i = a;
      bus.csr_data_i = d;
      if (bus.csr_re_i) rq.push_back('{cyc + 1, model_read(a)});

      bus.req_valid_i = ($urandom_range(0, 1) == 1);
      n = $urandom_range(0, NF - 1);
      bus.req_addr_i = {m_ader[n][31:8] ^ (($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0),
                        8'($urandom)};
      bus.req_am_i = ($urandom_range(0, 3) != 0) ? m_ader[n][7:2] : 6'($urandom);
      if (bus.req_valid_i) begin
        model_decode(bus.req_addr_i, bus.req_am_i, h, f);
        dq.push_back('{cyc + 2, h, f});
      end
      @(posedge clk_i);
      if (bus.csr_we_i) model_write(a, d);
      #1;
    end
    bus.csr_we_i = 0; bus.csr_re_i = 0; bus.req_valid_i = 0;
    repeat (4) tick();
    chk_en = 1'b0;
    check("rnd_drained", dq.size() + rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
